// File: rtl/pixel_grid_sampler.sv
// pixel_grid_sampler
// Assembles the camera byte stream into 16-bit pixels, follows the line/column
// position through one frame, keeps the pixel at the centre of every grid cell
// in a small buffer, and then streams the grid out row-major over valid/ready.
module pixel_grid_sampler #(
  parameter int LINES     = 120,
  parameter int COLUMNS   = 320,
  parameter int GRID_ROWS = 3,
  parameter int GRID_COLS = 3,
  parameter int S_DATA    = 16,
  parameter int HI_FIRST  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [S_DATA-1:0] out_data,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              busy,
  output logic              done
);

  localparam int S_LINE   = $clog2(LINES);
  localparam int S_COLUMN = $clog2(COLUMNS);
  // Degenerate one-line / one-column frames still need a 1-bit counter.
  localparam int LW       = (S_LINE > 0) ? S_LINE : 1;
  localparam int CW       = (S_COLUMN > 0) ? S_COLUMN : 1;
  localparam int DEPTH    = GRID_ROWS * GRID_COLS;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Capture datapath
  logic              phase_reg;
  logic [7:0]        half_reg;
  logic [LW-1:0]     line_reg;
  logic [CW-1:0]     column_reg;
  logic [S_DATA-1:0] pixel;
  logic              pixel_done;
  logic              last_pixel;

  // Sample-point detection
  logic [GRID_ROWS-1:0] row_hit;
  logic [GRID_COLS-1:0] col_hit;
  logic [2:0]           row_idx;
  logic [2:0]           col_idx;
  logic                 sample_hit;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;

  // Grid buffer
  logic [S_DATA-1:0] grid_mem [0:DEPTH-1];

  // Readout control
  logic [2:0]    rd_row_reg;
  logic [2:0]    rd_col_reg;
  logic [2:0]    rd_row_next;
  logic [2:0]    rd_col_next;
  logic [AW-1:0] rd_addr;
  logic          xfer;
  logic          last_entry;
  logic          load;
  logic          out_valid_next;
  logic          busy_next;
  logic          done_next;

  // ---------------------------------------------------------------------------
  // Pixel assembly: the stored half goes high or low depending on byte order.
  // ---------------------------------------------------------------------------
  generate
    if (HI_FIRST != 0) begin : g_hi_first
      assign pixel = {half_reg, byte_data};
    end else begin : g_lo_first
      assign pixel = {byte_data, half_reg};
    end
  endgenerate

  // A pixel completes on the second byte of a pair while capturing.
  assign pixel_done = (state_reg == CAPTURE) && byte_valid && phase_reg;
  assign last_pixel = (line_reg == LW'(LINES - 1)) && (column_reg == CW'(COLUMNS - 1));

  // ---------------------------------------------------------------------------
  // Sample-point comparators, one per grid row and per grid column. Each sample
  // sits at the centre of its cell: (2i+1)*SIZE/(2*CELLS).
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < GRID_ROWS; gi++) begin : g_row
      localparam int SAMPLE_LINE = (2 * gi + 1) * LINES / (2 * GRID_ROWS);
      assign row_hit[gi] = (line_reg == LW'(SAMPLE_LINE));
    end
    for (gi = 0; gi < GRID_COLS; gi++) begin : g_col
      localparam int SAMPLE_COLUMN = (2 * gi + 1) * COLUMNS / (2 * GRID_COLS);
      assign col_hit[gi] = (column_reg == CW'(SAMPLE_COLUMN));
    end
  endgenerate

  // Encode the matching row index (sample lines are distinct, so at most one hit).
  always_comb begin
    row_idx = 3'd0;
    for (int i = 0; i < GRID_ROWS; i++) begin
      if (row_hit[i]) begin
        row_idx = 3'(i);
      end
    end
  end

  // Encode the matching column index.
  always_comb begin
    col_idx = 3'd0;
    for (int i = 0; i < GRID_COLS; i++) begin
      if (col_hit[i]) begin
        col_idx = 3'(i);
      end
    end
  end

  assign sample_hit = (|row_hit) && (|col_hit);
  assign wr_en      = pixel_done && sample_hit;
  assign wr_addr    = AW'(int'(row_idx) * GRID_COLS + int'(col_idx));
  assign rd_addr    = AW'(int'(rd_row_reg) * GRID_COLS + int'(rd_col_reg));

  // Grid buffer write port; contents survive reset and are simply overwritten
  // by the next frame.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      grid_mem[wr_addr] <= pixel;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture counters and byte phase. Everything is held at zero outside
  // CAPTURE so that a new frame always starts on a clean pixel boundary.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_reg  <= 1'b0;
      half_reg   <= 8'd0;
      line_reg   <= '0;
      column_reg <= '0;
    end else if (state_reg != CAPTURE) begin
      phase_reg  <= 1'b0;
      half_reg   <= 8'd0;
      line_reg   <= '0;
      column_reg <= '0;
    end else if (byte_valid) begin
      phase_reg <= ~phase_reg;
      if (!phase_reg) begin
        half_reg <= byte_data;
      end else if (column_reg == CW'(COLUMNS - 1)) begin
        column_reg <= '0;
        line_reg   <= line_reg + LW'(1);
      end else begin
        column_reg <= column_reg + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign xfer       = out_valid && out_ready;
  assign last_entry = (out_row == 3'(GRID_ROWS - 1)) && (out_col == 3'(GRID_COLS - 1));

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (pixel_done && last_pixel) begin
          state_next = READOUT;
        end
      end
      READOUT: begin
        if (xfer && last_entry) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: output logic. Computes the next values of the registered outputs and
  // decides when the next buffer entry is fetched onto the output.
  always_comb begin
    load           = 1'b0;
    out_valid_next = out_valid;
    done_next      = 1'b0;
    rd_row_next    = rd_row_reg;
    rd_col_next    = rd_col_reg;
    case (state_reg)
      READOUT: begin
        if (xfer && last_entry) begin
          out_valid_next = 1'b0;
          done_next      = 1'b1;
        end else if (!out_valid || xfer) begin
          // Output register empty or being drained: present the next entry.
          load           = 1'b1;
          out_valid_next = 1'b1;
          if (rd_col_reg == 3'(GRID_COLS - 1)) begin
            rd_col_next = 3'd0;
            rd_row_next = rd_row_reg + 3'd1;
          end else begin
            rd_col_next = rd_col_reg + 3'd1;
          end
        end
      end
      default: begin
        out_valid_next = 1'b0;
        rd_row_next    = 3'd0;
        rd_col_next    = 3'd0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // Registered handshake/status outputs and the read pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_row    <= 3'd0;
      out_col    <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_row_reg <= 3'd0;
      rd_col_reg <= 3'd0;
    end else begin
      out_valid  <= out_valid_next;
      busy       <= busy_next;
      done       <= done_next;
      rd_row_reg <= rd_row_next;
      rd_col_reg <= rd_col_next;
      if (load) begin
        out_row <= rd_row_reg;
        out_col <= rd_col_reg;
      end
    end
  end

  // Registered buffer read straight into the output data register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= grid_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_pixel_grid_sampler.sv
// tb_pixel_grid_sampler
// Scoreboard bench: stimulus pushes hand-computed grid entries into per-DUT
// queues; a negedge monitor pops and compares on every accepted output.
// dut_a/dut_b: default 120x320 frame, 3x3 grid, MSB-first and LSB-first.
// dut_c: 8x16 frame, 2x4 grid, used for stall, spurious-input and reset cases.
module tb_pixel_grid_sampler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_ab, start_ab, valid_ab, ready_ab;
  logic [7:0]  data_a, data_b;
  logic        ov_a, busy_a, done_a, ov_b, busy_b, done_b;
  logic [15:0] od_a, od_b;
  logic [2:0]  or_a, oc_a, or_b, oc_b;

  logic        reset_c, start_c, valid_c, ready_c;
  logic [7:0]  data_c;
  logic        ov_c, busy_c, done_c;
  logic [15:0] od_c;
  logic [2:0]  or_c, oc_c;

  pixel_grid_sampler #(.HI_FIRST(1)) dut_a (
    .clock(clock), .reset(reset_ab), .start(start_ab), .byte_valid(valid_ab),
    .byte_data(data_a), .out_ready(ready_ab), .out_valid(ov_a), .out_data(od_a),
    .out_row(or_a), .out_col(oc_a), .busy(busy_a), .done(done_a));

  pixel_grid_sampler #(.HI_FIRST(0)) dut_b (
    .clock(clock), .reset(reset_ab), .start(start_ab), .byte_valid(valid_ab),
    .byte_data(data_b), .out_ready(ready_ab), .out_valid(ov_b), .out_data(od_b),
    .out_row(or_b), .out_col(oc_b), .busy(busy_b), .done(done_b));

  pixel_grid_sampler #(.LINES(8), .COLUMNS(16), .GRID_ROWS(2), .GRID_COLS(4), .HI_FIRST(1)) dut_c (
    .clock(clock), .reset(reset_c), .start(start_c), .byte_valid(valid_c),
    .byte_data(data_c), .out_ready(ready_c), .out_valid(ov_c), .out_data(od_c),
    .out_row(or_c), .out_col(oc_c), .busy(busy_c), .done(done_c));

  int          errors = 0;
  int          checks = 0;
  int          xfers [3];
  int          dones [3];
  logic        stall_pend [3];
  logic [21:0] held [3];
  // Entries are {row[2:0], col[2:0], data[15:0]}.
  logic [21:0] q0 [$];
  logic [21:0] q1 [$];
  logic [21:0] q2 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int d, input logic [2:0] r, input logic [2:0] c, input logic [15:0] v);
    case (d)
      0:       q0.push_back({r, c, v});
      1:       q1.push_back({r, c, v});
      default: q2.push_back({r, c, v});
    endcase
  endtask

  task automatic mon(input int d, input logic ov, input logic rdy, input logic [15:0] od,
                     input logic [2:0] orow, input logic [2:0] ocol, input logic dn, input logic bsy);
    logic [21:0] cur;
    logic [21:0] e;
    bit          have;
    cur = {orow, ocol, od};
    if (stall_pend[d]) begin
      check($sformatf("hold_valid[%0d]", d), 32'(ov), 32'd1);
      check($sformatf("hold_payload[%0d]", d), 32'(cur), 32'(held[d]));
    end
    stall_pend[d] = ov & ~rdy;
    held[d]       = cur;
    if (ov && rdy) begin
      xfers[d]++;
      have = 1'b0;
      e    = '0;
      case (d)
        0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output[%0d]: actual=0x%0h required=none", d, cur);
      end else begin
        check($sformatf("out_data[%0d] r%0d c%0d", d, e[21:19], e[18:16]), 32'(od), 32'(e[15:0]));
        check($sformatf("out_row_col[%0d]", d), 32'({orow, ocol}), 32'(e[21:16]));
      end
    end
    if (dn) begin
      dones[d]++;
      check($sformatf("busy_at_done[%0d]", d), 32'(bsy), 32'd0);
    end
  endtask

  // Monitor: samples all three DUTs on the falling edge.
  always @(negedge clock) begin
    mon(0, ov_a, ready_ab, od_a, or_a, oc_a, done_a, busy_a);
    mon(1, ov_b, ready_ab, od_b, or_b, oc_b, done_b, busy_b);
    mon(2, ov_c, ready_c,  od_c, or_c, oc_c, done_c, busy_c);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int d, input int target, input bit stall);
    for (int i = 0; i < 300; i++) begin
      if (dones[d] >= target) break;
      if (d == 2) ready_c = stall ? (i % 3 == 2) : 1'b1;
      tick();
    end
    if (d == 2) ready_c = 1'b1;
    check($sformatf("done_count[%0d]", d), 32'(dones[d]), 32'(target));
  endtask

  // Small-frame expectations: sample lines 2,6 and columns 2,6,10,14;
  // pixel value is {line + salt, column}.
  task automatic expect_c(input logic [7:0] salt);
    logic [7:0] lines_tab [2];
    logic [7:0] cols_tab [4];
    lines_tab = '{8'd2, 8'd6};
    cols_tab  = '{8'd2, 8'd6, 8'd10, 8'd14};
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        push_exp(2, 3'(r), 3'(c), {lines_tab[r] + salt, cols_tab[c]});
      end
    end
  endtask

  // Sends npix pixels of the small frame, MSB byte first.
  task automatic send_c(input logic [7:0] salt, input int npix, input bit gaps, input bit spur);
    logic [15:0] pix;
    for (int k = 0; k < npix; k++) begin
      pix     = {8'(k / 16) + salt, 8'(k % 16)};
      start_c = spur && (k == 37);
      valid_c = 1'b1;
      data_c  = pix[15:8];
      tick();
      start_c = 1'b0;
      data_c  = pix[7:0];
      tick();
      valid_c = 1'b0;
      if (gaps && (k % 5 == 0)) tick();
    end
  endtask

  task automatic pulse_start_c();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
  endtask

  logic [15:0] exp_def [9];
  logic [15:0] pix;

  initial begin
    for (int d = 0; d < 3; d++) begin
      xfers[d] = 0; dones[d] = 0; stall_pend[d] = 1'b0; held[d] = '0;
    end
    reset_ab = 1'b0; start_ab = 1'b0; valid_ab = 1'b0; ready_ab = 1'b1;
    data_a = 8'd0; data_b = 8'd0;
    reset_c = 1'b0; start_c = 1'b0; valid_c = 1'b0; ready_c = 1'b1; data_c = 8'd0;
    repeat (2) tick();

    // Reset state
    check("reset_out_valid_a", 32'(ov_a), 32'd0);
    check("reset_out_data_a", 32'(od_a), 32'd0);
    check("reset_out_row_col_a", 32'({or_a, oc_a}), 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_done_a", 32'(done_a), 32'd0);
    check("reset_out_valid_c", 32'(ov_c), 32'd0);
    reset_ab = 1'b1;
    reset_c  = 1'b1;
    tick();

    // Bytes while idle, then start together with a byte: all discarded.
    valid_ab = 1'b1; data_a = 8'hEE; data_b = 8'hEE;
    repeat (5) tick();
    check("idle_busy_a", 32'(busy_a), 32'd0);
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    valid_ab = 1'b0;
    check("capture_busy_a", 32'(busy_a), 32'd1);
    check("capture_busy_b", 32'(busy_b), 32'd1);

    // Default grid: lines 20,60,100 (0x14,0x3C,0x64); cols 53,160,266 (low bytes 0x35,0xA0,0x0A).
    exp_def = '{16'h1435, 16'h14A0, 16'h140A, 16'h3C35, 16'h3CA0, 16'h3C0A,
                16'h6435, 16'h64A0, 16'h640A};
    for (int i = 0; i < 9; i++) begin
      push_exp(0, 3'(i / 3), 3'(i % 3), exp_def[i]);
      push_exp(1, 3'(i / 3), 3'(i % 3), exp_def[i]);
    end

    // Full default frame; a start pulse mid-capture must be ignored.
    for (int l = 0; l < 120; l++) begin
      for (int c = 0; c < 320; c++) begin
        pix      = {8'(l), 8'(c)};
        start_ab = (l == 50) && (c == 10);
        valid_ab = 1'b1;
        data_a   = pix[15:8];
        data_b   = pix[7:0];
        tick();
        start_ab = 1'b0;
        data_a   = pix[7:0];
        data_b   = pix[15:8];
        tick();
      end
    end
    valid_ab = 1'b0;
    wait_done(0, 1, 1'b0);
    wait_done(1, 1, 1'b0);

    // Small frame, ready held high, idle gaps between some pixels.
    pulse_start_c();
    expect_c(8'h00);
    send_c(8'h00, 128, 1'b1, 1'b0);
    wait_done(2, 1, 1'b0);

    // Idle bytes, start with a byte, mid-capture start, stalled readout.
    valid_c = 1'b1; data_c = 8'h77;
    repeat (3) tick();
    start_c = 1'b1; data_c = 8'h99;
    tick();
    start_c = 1'b0; valid_c = 1'b0;
    expect_c(8'h30);
    send_c(8'h30, 128, 1'b0, 1'b1);
    wait_done(2, 2, 1'b1);

    // Partial frame ending on an odd byte, then reset.
    pulse_start_c();
    send_c(8'h40, 60, 1'b0, 1'b0);
    valid_c = 1'b1; data_c = 8'hAB;
    tick();
    valid_c = 1'b0;
    reset_c = 1'b0;
    tick();
    check("mid_reset_out_valid_c", 32'(ov_c), 32'd0);
    check("mid_reset_out_data_c", 32'(od_c), 32'd0);
    check("mid_reset_out_row_col_c", 32'({or_c, oc_c}), 32'd0);
    check("mid_reset_busy_c", 32'(busy_c), 32'd0);
    check("mid_reset_done_c", 32'(done_c), 32'd0);
    reset_c = 1'b1;
    tick();
    pulse_start_c();
    expect_c(8'h50);
    send_c(8'h50, 128, 1'b1, 1'b0);
    wait_done(2, 3, 1'b0);

    repeat (3) tick();
    check("transfers_a", 32'(xfers[0]), 32'd9);
    check("transfers_b", 32'(xfers[1]), 32'd9);
    check("transfers_c", 32'(xfers[2]), 32'd24);
    check("done_pulses_a", 32'(dones[0]), 32'd1);
    check("done_pulses_c", 32'(dones[2]), 32'd3);
    check("leftover_a", 32'(q0.size()), 32'd0);
    check("leftover_b", 32'(q1.size()), 32'd0);
    check("leftover_c", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
